// File: rtl/vdl_pkg.sv
// Variable delay line shared constants.
// Default geometry and derived-width helpers.
package vdl_pkg;

  localparam int VDL_WIDTH = 8;
  localparam int VDL_DEPTH = 16;

  // Tap-select width; never narrower than one bit.
  function automatic int vdl_sel_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width; must hold the value DEPTH.
  function automatic int vdl_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vdl_stage.sv
// One delay-line stage: data plus valid bit.
// Flush beats shift; async active-low reset.
module vdl_stage #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Capture on enable, flush on clear.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/var_delay_line.sv
// Variable-length delay line with tap select.
// Stage chain, tap mux and occupancy counter.
module var_delay_line
  import vdl_pkg::*;
#(
  parameter  int WIDTH = VDL_WIDTH,
  parameter  int DEPTH = VDL_DEPTH,
  localparam int SELW  = vdl_sel_w(DEPTH),
  localparam int CNTW  = vdl_cnt_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SELW-1:0]    i_dly_sel,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [WIDTH*DEPTH-1:0] o_taps,
  output logic [CNTW-1:0]    o_cnt,
  output logic               o_sel_err
);

  logic [WIDTH:0]  stg_d [DEPTH];
  logic [WIDTH:0]  stg_q [DEPTH];
  logic            sel_ovr;
  logic [SELW-1:0] tap_idx;
  logic [WIDTH:0]  tap_q;
  logic            v_out;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            err_q;

  // Stage k feeds stage k+1; stage 0 takes the input.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign stg_d[k] = {i_valid, i_data};
    end else begin : g_body
      assign stg_d[k] = stg_q[k-1];
    end

    vdl_stage #(
      .W (WIDTH + 1)
    ) u_stg (
      .CLK   (CLK),
      .RST_n (RST_n),
      .i_en  (i_en),
      .i_clr (i_clr),
      .i_d   (stg_d[k]),
      .o_q   (stg_q[k])
    );

    assign o_taps[k*WIDTH +: WIDTH] = stg_q[k][WIDTH-1:0];
  end

  // Tap mux; out-of-range selects clamp to the last stage.
  always_comb begin
    sel_ovr = (int'(i_dly_sel) >= DEPTH);
    tap_idx = i_dly_sel;
    if (sel_ovr) begin
      tap_idx = SELW'(DEPTH - 1);
    end
    tap_q = stg_q[tap_idx];
  end

  assign o_data  = tap_q[WIDTH-1:0];
  assign o_valid = tap_q[WIDTH];

  // Occupancy: add entering valid, drop leaving valid.
  always_comb begin
    v_out = stg_q[DEPTH-1][WIDTH];
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = cnt_q + CNTW'(i_valid) - CNTW'(v_out);
    end
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sticky out-of-range select flag.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      err_q <= 1'b0;
    end else if (i_clr) begin
      err_q <= 1'b0;
    end else if (sel_ovr) begin
      err_q <= 1'b1;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_sel_err = err_q;

  a_cnt_range : assert property (
    @(posedge CLK) disable iff (!RST_n)
    int'(cnt_q) <= DEPTH
  );

endmodule

// File: tb/tb_var_delay_line.sv
// Directed scoreboard bench for var_delay_line.
// Two instances: DEPTH=16 and DEPTH=12.
module tb_var_delay_line;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        en;
  logic        clr;
  logic        valid;
  logic [7:0]  data;
  logic [3:0]  sel16;
  logic [3:0]  sel12;

  logic        o_valid16;
  logic [7:0]  o_data16;
  logic [127:0] o_taps16;
  logic [4:0]  o_cnt16;
  logic        o_err16;

  logic        o_valid12;
  logic [7:0]  o_data12;
  logic [95:0] o_taps12;
  logic [3:0]  o_cnt12;
  logic        o_err12;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hist[$];
  logic [7:0] e;

  always #5 CLK = ~CLK;

  var_delay_line #(.WIDTH(8), .DEPTH(16)) dut16 (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .i_en      (en),
    .i_clr     (clr),
    .i_valid   (valid),
    .i_data    (data),
    .i_dly_sel (sel16),
    .o_valid   (o_valid16),
    .o_data    (o_data16),
    .o_taps    (o_taps16),
    .o_cnt     (o_cnt16),
    .o_sel_err (o_err16)
  );

  var_delay_line #(.WIDTH(8), .DEPTH(12)) dut12 (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .i_en      (en),
    .i_clr     (clr),
    .i_valid   (valid),
    .i_data    (data),
    .i_dly_sel (sel12),
    .o_valid   (o_valid12),
    .o_data    (o_data12),
    .o_taps    (o_taps12),
    .o_cnt     (o_cnt12),
    .o_sel_err (o_err12)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
    data  = '0;
    sel16 = '0;
    sel12 = '0;

    #3;
    chk("rst_valid", 64'(o_valid16), 64'd0);
    chk("rst_data",  64'(o_data16),  64'd0);
    chk("rst_taps",  64'(|o_taps16), 64'd0);
    chk("rst_cnt",   64'(o_cnt16),   64'd0);
    chk("rst_err",   64'(o_err12),   64'd0);
    #5;
    RST_n = 1'b1;

    // Streaming with 4-edge delay.
    sel16 = 4'd3;
    en    = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = 8'(i + 1);
      exp_q.push_back(data);
      step();
      if (i >= 3) begin
        e = exp_q.pop_front();
        chk("t1_data",  64'(o_data16),  64'(e));
        chk("t1_valid", 64'(o_valid16), 64'd1);
      end else begin
        chk("t1_nvalid", 64'(o_valid16), 64'd0);
      end
    end
    exp_q.delete();

    // Single-edge delay with enable toggling.
    clr = 1'b1;
    step();
    clr   = 1'b0;
    sel16 = 4'd0;
    e     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      en   = (i % 2 == 0);
      data = 8'hA5 + 8'(i);
      if (en) exp_q.push_back(data);
      step();
      if (en) e = exp_q.pop_front();
      chk("t2_data",  64'(o_data16),  64'(e));
      chk("t2_valid", 64'(o_valid16), 64'd1);
    end
    en = 1'b1;

    // Occupancy fill, saturate at full, drain.
    clr = 1'b1;
    step();
    clr   = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'(i);
      step();
      chk("t3_fill", 64'(o_cnt16), 64'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_full", 64'(o_cnt16), 64'd16);
    end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_drain", 64'(o_cnt16), 64'(15 - i));
    end

    // Flush a full chain with enable low.
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'hC0 + 8'(i);
      step();
    end
    chk("t4_full", 64'(o_cnt16), 64'd16);
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_cnt",   64'(o_cnt16),   64'd0);
    chk("t4_taps",  64'(|o_taps16), 64'd0);
    chk("t4_valid", 64'(o_valid16), 64'd0);
    en = 1'b1;

    // Out-of-range tap select on DEPTH=12.
    for (int i = 0; i < 14; i++) begin
      data = 8'h30 + 8'(i);
      hist.push_front(data);
      step();
    end
    sel12 = 4'd13;
    #1;
    chk("t5_data",   64'(o_data12),  64'(hist[11]));
    chk("t5_valid",  64'(o_valid12), 64'd1);
    chk("t5_err_pre", 64'(o_err12),  64'd0);
    en = 1'b0;
    step();
    chk("t5_err_set", 64'(o_err12),  64'd1);
    chk("t5_hold",   64'(o_data12),  64'(hist[11]));
    sel12 = 4'd2;
    step();
    chk("t5_sticky", 64'(o_err12),   64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr",    64'(o_err12),   64'd0);
    sel12 = 4'd11;
    step();
    chk("t5_max_ok", 64'(o_err12),   64'd0);
    en = 1'b1;

    // Async reset mid-stream.
    sel16 = 4'd0;
    sel12 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      data = 8'h50 + 8'(i);
      step();
    end
    chk("t6_pre", 64'(o_data16), 64'h52);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t6_data",  64'(o_data16),  64'd0);
    chk("t6_valid", 64'(o_valid16), 64'd0);
    chk("t6_taps",  64'(|o_taps16), 64'd0);
    chk("t6_cnt",   64'(o_cnt16),   64'd0);
    chk("t6_taps12", 64'(|o_taps12), 64'd0);
    step();
    chk("t6_inrst", 64'(|o_taps16), 64'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    data  = 8'h77;
    step();
    chk("t6_d0",   64'(o_data16),          64'h77);
    chk("t6_cnt1", 64'(o_cnt16),           64'd1);
    chk("t6_hi",   64'(|o_taps16[127:8]),  64'd0);
    sel16 = 4'd1;
    #1;
    chk("t6_s1v",  64'(o_valid16),         64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/var_delay_line.md
VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (1..64).
REQ-002 Parameter DEPTH, default 16, number of register stages (2..256).
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST_n  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  shift enable; low = whole chain holds.
REQ-006 i_clr  input  1  synchronous flush of chain, valid bits and counter.
REQ-007 i_valid  input  1  qualifies i_data.
REQ-008 i_data  input  WIDTH  sample entering stage 0.
REQ-009 i_dly_sel  input  SELW = max(1,$clog2(DEPTH))  tap select; delay = i_dly_sel+1 enabled cycles.
REQ-010 o_valid  output  1  valid bit of selected tap.
REQ-011 o_data  output  WIDTH  data of selected tap.
REQ-012 o_taps  output  WIDTH*DEPTH  all stage data; stage k at bits [k*WIDTH +: WIDTH].
REQ-013 o_cnt  output  $clog2(DEPTH+1)  number of valid stages in chain.
REQ-014 o_sel_err  output  1  registered flag: i_dly_sel >= DEPTH was sampled.

Function
REQ-015 Chain SHALL hold DEPTH stages, each storing WIDTH data bits and one valid bit.
REQ-016 On rising CLK with i_en=1 and i_clr=0: stage0 <= {i_valid,i_data}; stage k <= stage k-1 for k=1..DEPTH-1, all non-blocking, one shift per edge.
REQ-017 With i_en=0 and i_clr=0 every stage, o_cnt and valid bits SHALL hold.
REQ-018 i_clr=1 SHALL, at the edge, zero all data, valid bits and o_cnt regardless of i_en; input on that edge is dropped.
REQ-019 o_data/o_valid SHALL be a combinational mux of stage[i_dly_sel]; no extra register, so data presented at edge N appears after i_dly_sel+1 enabled edges.
REQ-020 i_dly_sel changes SHALL take effect immediately on the mux; no drain or refill; skipped/repeated samples are the user's concern.
REQ-021 i_dly_sel >= DEPTH (non-power-of-2 DEPTH) SHALL select stage DEPTH-1 and set o_sel_err on next edge; o_sel_err clears only on i_clr or reset.
REQ-022 o_cnt update per enabled edge: o_cnt + i_valid - valid[DEPTH-1]; never exceeds DEPTH, never below 0 (assertion).
REQ-023 Simultaneous valid in and valid out at full chain SHALL leave o_cnt = DEPTH.
REQ-024 Invalid entries (i_valid=0) shift like valid ones; data contents of invalid stages are don't-care but deterministic (captured i_data).

Reset
REQ-025 RST_n low SHALL asynchronously clear all stage data, valid bits, o_cnt, o_sel_err to 0.
REQ-026 Outputs during reset: o_valid=0, o_data=0, o_taps=0, o_cnt=0, o_sel_err=0.
REQ-027 Reset assertion mid-stream SHALL discard all contents; first shift occurs on first rising CLK after RST_n deasserts.

Structure
REQ-028 Package vdl_pkg SHALL hold default WIDTH/DEPTH constants and a function computing SELW/CNTW.
REQ-029 One sub-module vdl_stage (WIDTH+1-bit register with en, clr, async reset) SHALL be instantiated DEPTH times via generate.
REQ-030 Tap mux and occupancy counter SHALL live in the top module.

Verification
REQ-031 Reset then en=1, valid=1, data=0x01..0x14 on consecutive edges, sel=3 -> o_data=0x01 after 4th edge, o_valid=1, then increments each cycle.
REQ-032 sel=0, en toggled 1/0 each cycle, data 0xA5 -> o_data follows with 1 enabled-edge delay, holds on en=0 edges.
REQ-033 Fill 16 valid samples, DEPTH=16 -> o_cnt=16; keep feeding valid -> stays 16; feed valid=0 for 5 edges -> o_cnt=11.
REQ-034 Chain full, assert i_clr with en=0 and valid=1 -> next edge o_cnt=0, o_taps=0, o_valid=0.
REQ-035 DEPTH=12, sel=13 -> o_data equals stage 11, o_sel_err=1 after next edge, cleared by i_clr.
REQ-036 RST_n pulsed low asynchronously mid-stream (between edges) -> all outputs 0 immediately; data restarts from stage 0 afterwards.
